lcd_edit_ctrl: RTL and testbench

Consumes the one-cycle debounced button pulses (center/north/south/east/west) and turns them into cursor movement and character edits on a 2x16 character screen. It holds a local copy of the screen contents and issues single-cell write requests to the LCD driver over a req/ack handshake. It sits between the button debouncer and the LCD driver in the rotary-encoder/LCD design.

---
 rtl/lcd_edit_ctrl_if.sv | 25 ++
 rtl/lcd_edit_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lcd_edit_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_edit_ctrl_if.sv
// Button-pulse inputs and single-cell write handshake between
// lcd_edit_ctrl (master) and the debouncer/LCD driver side (slave).
interface lcd_edit_ctrl_if;
    logic       dbcenter;
    logic       dbnorth;
    logic       dbsouth;
    logic       dbeast;
    logic       dbwest;
    logic       wr_ack;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        input  dbcenter, dbnorth, dbsouth, dbeast, dbwest,
        input  wr_ack,
        output wr_req, wr_addr, wr_data
    );

    modport slave (
        output dbcenter, dbnorth, dbsouth, dbeast, dbwest,
        output wr_ack,
        input  wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/lcd_edit_ctrl.sv
// Cursor/edit controller for a 2x16 character LCD: keeps a local screen copy,
// refreshes it after reset and issues one req/ack write per edited cell.
module lcd_edit_ctrl #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] CHAR_MIN  = 8'h20,
    parameter logic [7:0] CHAR_MAX  = 8'h7E
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_edit_ctrl_if.master       bus,
    output logic                  cursor_row,
    output logic [3:0]            cursor_col,
    output logic                  edit_mode,
    output logic                  busy
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT_ACK} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_CENTER, EV_NORTH, EV_SOUTH, EV_EAST, EV_WEST} ev_t;

    state_t     state_q, state_d;
    ev_t        pend_q, pend_d, fresh_ev, cur_ev;
    logic [4:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       edit_q, edit_d;

    logic [7:0] buf_mem [32];
    logic       buf_we;
    logic [4:0] buf_waddr;
    logic [7:0] buf_wdata;

    logic [4:0] cell_idx;
    logic [7:0] cell_val, cell_inc, cell_dec;

    always_comb begin
        fresh_ev = EV_NONE;
        if (bus.dbcenter)     fresh_ev = EV_CENTER;
        else if (bus.dbnorth) fresh_ev = EV_NORTH;
        else if (bus.dbsouth) fresh_ev = EV_SOUTH;
        else if (bus.dbeast)  fresh_ev = EV_EAST;
        else if (bus.dbwest)  fresh_ev = EV_WEST;
    end

    // Out-of-range cell values wrap as if they sat on the nearer bound.
    assign cell_idx = {row_q, col_q};
    assign cell_val = buf_mem[cell_idx];
    assign cell_inc = (cell_val >= CHAR_MAX) ? CHAR_MIN : cell_val + 8'd1;
    assign cell_dec = (cell_val <= CHAR_MIN) ? CHAR_MAX : cell_val - 8'd1;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;
        edit_d    = edit_q;
        buf_we    = 1'b0;
        buf_waddr = cnt_q;
        buf_wdata = FILL_CHAR;
        cur_ev    = EV_NONE;

        case (state_q)
            S_INIT: begin
                if (req_q) begin
                    if (bus.wr_ack) begin
                        req_d = 1'b0;
                        if (cnt_q == 5'd31) state_d = S_IDLE;
                        else                cnt_d   = cnt_q + 5'd1;
                    end
                end else begin
                    req_d     = 1'b1;
                    addr_d    = cnt_q;
                    data_d    = FILL_CHAR;
                    buf_we    = 1'b1;
                    buf_waddr = cnt_q;
                    buf_wdata = FILL_CHAR;
                end
            end

            S_IDLE: begin
                // A pending event shadows any fresh pulse arriving this cycle.
                cur_ev = (pend_q != EV_NONE) ? pend_q : fresh_ev;
                pend_d = EV_NONE;
                case (cur_ev)
                    EV_CENTER: edit_d = ~edit_q;
                    EV_NORTH, EV_SOUTH: begin
                        if (edit_q) begin
                            buf_we    = 1'b1;
                            buf_waddr = cell_idx;
                            buf_wdata = (cur_ev == EV_NORTH) ? cell_inc : cell_dec;
                            req_d     = 1'b1;
                            addr_d    = cell_idx;
                            data_d    = buf_wdata;
                            state_d   = S_WAIT_ACK;
                        end else begin
                            row_d = ~row_q;
                        end
                    end
                    EV_EAST:  col_d = col_q + 4'd1;
                    EV_WEST:  col_d = col_q - 4'd1;
                    default: ;
                endcase
            end

            S_WAIT_ACK: begin
                if (pend_q == EV_NONE) pend_d = fresh_ev;
                if (bus.wr_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_INIT;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= EV_NONE;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            row_q  <= 1'b0;
            col_q  <= '0;
            edit_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
            row_q  <= row_d;
            col_q  <= col_d;
            edit_q <= edit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && buf_we) buf_mem[buf_waddr] <= buf_wdata;
    end

    assign bus.wr_req  = req_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;
    assign edit_mode   = edit_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_edit_ctrl.sv
// Bench for lcd_edit_ctrl: an ack responder pops expected writes from a
// scoreboard queue; scenario tasks check cursor/mode/handshake inline.
module tb_lcd_edit_ctrl;

    localparam logic [4:0] B_C = 5'b10000, B_N = 5'b01000, B_S = 5'b00100,
                           B_E = 5'b00010, B_W = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_edit_ctrl_if bus();
    logic       cursor_row;
    logic [3:0] cursor_col;
    logic       edit_mode;
    logic       busy;

    lcd_edit_ctrl #(.FILL_CHAR(8'h20), .CHAR_MIN(8'h20), .CHAR_MAX(8'h7E)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .edit_mode(edit_mode), .busy(busy)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [12:0] exp_q[$];
    bit          ack_en    = 1'b0;
    int          ack_delay = 2;
    int          wait_cnt  = 0;

    logic [7:0] mdl_buf [32];
    logic       mdl_row;
    logic [3:0] mdl_col;
    logic       mdl_edit;

    function automatic logic [7:0] mdl_inc(input logic [7:0] v);
        return (v >= 8'h7E) ? 8'h20 : v + 8'd1;
    endfunction

    function automatic logic [7:0] mdl_dec(input logic [7:0] v);
        return (v <= 8'h20) ? 8'h7E : v - 8'd1;
    endfunction

    // LCD-driver stand-in: acks after ack_delay idle negedges, checking each accepted write.
    always @(negedge clk) begin
        logic [12:0] exp_w;
        if (!ack_en) begin
            bus.wr_ack = 1'b0;
            wait_cnt   = 0;
        end else if (bus.wr_ack) begin
            bus.wr_ack = 1'b0;
            wait_cnt   = 0;
        end else if (bus.wr_req) begin
            if (wait_cnt >= ack_delay) begin
                n_cmp++;
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL write_seq: got addr=%0d data=%h, required addr=%0d data=%h",
                                 bus.wr_addr, bus.wr_data, exp_w[12:8], exp_w[7:0]);
                    end
                end
                bus.wr_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        {bus.dbcenter, bus.dbnorth, bus.dbsouth, bus.dbeast, bus.dbwest} = m;
        @(negedge clk);
        {bus.dbcenter, bus.dbnorth, bus.dbsouth, bus.dbeast, bus.dbwest} = '0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_refresh();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            exp_q.push_back({a, 8'h20});
            mdl_buf[i] = 8'h20;
        end
        mdl_row = 1'b0; mdl_col = '0; mdl_edit = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        ack_en = 1'b0;
        {bus.dbcenter, bus.dbnorth, bus.dbsouth, bus.dbeast, bus.dbwest} = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", bus.wr_req); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b, required 1", busy); end
        n_cmp++; if ({bus.wr_addr, bus.wr_data} !== 13'd0) begin n_err++; $display("FAIL rst_bus: got %h/%h, required 0/00", bus.wr_addr, bus.wr_data); end
        n_cmp++; if ({cursor_row, cursor_col, edit_mode} !== 6'd0) begin n_err++; $display("FAIL rst_cursor: got row=%b col=%0d edit=%b, required 0/0/0", cursor_row, cursor_col, edit_mode); end
        expect_refresh();
        n_wr = 0;
        ack_delay = 2;
        ack_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.wr_req, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd0, 8'h20}) begin n_err++; $display("FAIL first_write: got req=%b addr=%0d data=%h, required 1/0/20", bus.wr_req, bus.wr_addr, bus.wr_data); end
        wait_drain(1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL refresh_timeout: got %0d left, required 0", exp_q.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_before_last_ack: got %b, required 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if ({busy, bus.wr_req} !== 2'b00) begin n_err++; $display("FAIL busy_after_refresh: got busy=%b req=%b, required 0/0", busy, bus.wr_req); end
        n_cmp++; if (n_wr !== 32) begin n_err++; $display("FAIL refresh_count: got %0d, required 32", n_wr); end
    endtask

    task automatic test_cursor_wrap();
        pulse(B_W); mdl_col = 4'd15;
        n_cmp++; if ({cursor_row, cursor_col, bus.wr_req} !== {1'b0, 4'd15, 1'b0}) begin n_err++; $display("FAIL west_wrap: got row=%b col=%0d req=%b, required 0/15/0", cursor_row, cursor_col, bus.wr_req); end
        for (int i = 0; i < 16; i++) begin
            pulse(B_E); mdl_col = mdl_col + 4'd1;
            n_cmp++; if (cursor_col !== mdl_col) begin n_err++; $display("FAIL east_step%0d: got %0d, required %0d", i, cursor_col, mdl_col); end
        end
        pulse(B_N); mdl_row = 1'b1;
        n_cmp++; if ({cursor_row, bus.wr_req} !== 2'b10) begin n_err++; $display("FAIL nav_north: got row=%b req=%b, required 1/0", cursor_row, bus.wr_req); end
        pulse(B_S); mdl_row = 1'b0;
        pulse(B_E); mdl_col = 4'd0;
        n_cmp++; if ({cursor_row, cursor_col} !== 5'd0) begin n_err++; $display("FAIL nav_home: got row=%b col=%0d, required 0/0", cursor_row, cursor_col); end
    endtask

    task automatic test_edit_wrap();
        bit ok;
        logic [4:0] idx;
        pulse(B_C); mdl_edit = 1'b1;
        n_cmp++; if ({edit_mode, bus.wr_req} !== 2'b10) begin n_err++; $display("FAIL center_edit: got edit=%b req=%b, required 1/0", edit_mode, bus.wr_req); end
        idx = {mdl_row, mdl_col};
        mdl_buf[idx] = mdl_dec(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        pulse(B_S);
        n_cmp++; if ({bus.wr_req, bus.wr_addr, bus.wr_data} !== {1'b1, 5'd0, 8'h7E}) begin n_err++; $display("FAIL south_wrap: got req=%b addr=%0d data=%h, required 1/0/7e", bus.wr_req, bus.wr_addr, bus.wr_data); end
        wait_drain(50, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL south_ack_timeout: got %0d left, required 0", exp_q.size()); end
        mdl_buf[idx] = mdl_inc(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        pulse(B_N);
        n_cmp++; if ({bus.wr_req, bus.wr_data} !== {1'b1, 8'h20}) begin n_err++; $display("FAIL north_wrap: got req=%b data=%h, required 1/20", bus.wr_req, bus.wr_data); end
        wait_drain(50, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL north_ack_timeout: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_priority();
        pulse(B_C | B_E); mdl_edit = ~mdl_edit;
        n_cmp++; if ({edit_mode, cursor_col} !== {mdl_edit, mdl_col}) begin n_err++; $display("FAIL prio_center_east: got edit=%b col=%0d, required %b/%0d", edit_mode, cursor_col, mdl_edit, mdl_col); end
        pulse(B_N | B_S | B_E); mdl_row = ~mdl_row;
        n_cmp++; if ({cursor_row, cursor_col, bus.wr_req} !== {mdl_row, mdl_col, 1'b0}) begin n_err++; $display("FAIL prio_north: got row=%b col=%0d, required %b/%0d", cursor_row, cursor_col, mdl_row, mdl_col); end
        pulse(B_S | B_E | B_W); mdl_row = ~mdl_row;
        n_cmp++; if ({cursor_row, cursor_col} !== {mdl_row, mdl_col}) begin n_err++; $display("FAIL prio_south: got row=%b col=%0d, required %b/%0d", cursor_row, cursor_col, mdl_row, mdl_col); end
        pulse(B_E | B_W); mdl_col = mdl_col + 4'd1;
        n_cmp++; if (cursor_col !== mdl_col) begin n_err++; $display("FAIL prio_east_west: got %0d, required %0d", cursor_col, mdl_col); end
    endtask

    task automatic test_pending();
        bit seen;
        logic [4:0] idx;
        logic [3:0] col0;
        ack_delay = 6;
        pulse(B_C); mdl_edit = 1'b1;
        idx = {mdl_row, mdl_col};
        mdl_buf[idx] = mdl_inc(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        col0 = mdl_col;
        pulse(B_N);
        pulse(B_E);
        pulse(B_W);
        n_cmp++; if ({bus.wr_req, cursor_col} !== {1'b1, col0}) begin n_err++; $display("FAIL pend_hold: got req=%b col=%0d, required 1/%0d", bus.wr_req, cursor_col, col0); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (bus.wr_ack) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL pend_ack_timeout: got no ack, required ack"); end
        @(posedge clk); #1;
        n_cmp++; if ({busy, cursor_col} !== {1'b0, col0}) begin n_err++; $display("FAIL pend_idle_entry: got busy=%b col=%0d, required 0/%0d", busy, cursor_col, col0); end
        @(posedge clk); #1;
        mdl_col = col0 + 4'd1;
        n_cmp++; if (cursor_col !== mdl_col) begin n_err++; $display("FAIL pend_apply: got %0d, required %0d", cursor_col, mdl_col); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if ({cursor_col, bus.wr_req} !== {mdl_col, 1'b0}) begin n_err++; $display("FAIL pend_second_dropped: got col=%0d req=%b, required %0d/0", cursor_col, bus.wr_req, mdl_col); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [4:0] idx;
        int wr0;
        ack_delay = 0;
        idx = {mdl_row, mdl_col};
        mdl_buf[idx] = mdl_inc(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        mdl_buf[idx] = mdl_inc(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        wr0 = n_wr;
        @(negedge clk); bus.dbnorth = 1'b1;
        @(negedge clk); bus.dbnorth = 1'b1;
        @(negedge clk); bus.dbnorth = 1'b0; bus.dbsouth = 1'b1;
        @(negedge clk); bus.dbsouth = 1'b0;
        wait_drain(50, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d left, required 0", exp_q.size()); end
        repeat (4) @(negedge clk);
        n_cmp++; if (n_wr - wr0 !== 2) begin n_err++; $display("FAIL b2b_write_count: got %0d, required 2", n_wr - wr0); end
        n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got req=%b, required 0", bus.wr_req); end
        mdl_buf[idx] = mdl_dec(mdl_buf[idx]);
        exp_q.push_back({idx, mdl_buf[idx]});
        pulse(B_S);
        n_cmp++; if (bus.wr_data !== mdl_buf[idx]) begin n_err++; $display("FAIL b2b_after: got %h, required %h", bus.wr_data, mdl_buf[idx]); end
        wait_drain(50, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_after_timeout: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        @(negedge clk);
        ack_en = 1'b0;
        exp_q.delete();
        pulse(B_N);
        n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL midrst_req_before: got %b, required 1", bus.wr_req); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.wr_req, edit_mode, cursor_row, cursor_col, busy} !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin n_err++; $display("FAIL midrst_clear: got req=%b edit=%b row=%b col=%0d busy=%b, required 0/0/0/0/1", bus.wr_req, edit_mode, cursor_row, cursor_col, busy); end
        expect_refresh();
        n_wr = 0;
        ack_delay = 0;
        ack_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        n_cmp++; if ({bus.wr_req, bus.wr_addr} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL midrst_restart: got req=%b addr=%0d, required 1/0", bus.wr_req, bus.wr_addr); end
        wait_drain(1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_refresh_timeout: got %0d left, required 0", exp_q.size()); end
        @(posedge clk); #1;
        n_cmp++; if ({busy, n_wr} !== {1'b0, 32'd32}) begin n_err++; $display("FAIL midrst_done: got busy=%b writes=%0d, required 0/32", busy, n_wr); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cursor_wrap();
        test_edit_wrap();
        test_priority();
        test_pending();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
